// File: rtl/btb_pkg.sv
// Shared types and sizing for the BTB write-side controller.
package btb_pkg;

  localparam int BTB_INDEX = 6;
  localparam int BTB_DEPTH = 2 ** BTB_INDEX;
  localparam int BTB_WIDTH = 32;

  typedef enum logic {
    BTB_INIT,
    BTB_RUN
  } btb_state_e;

  typedef struct packed {
    logic [BTB_INDEX-1:0] index;
    logic [BTB_WIDTH-1:0] data;
  } btb_upd_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO holding pending BTB updates; flush empties it in one cycle.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  btb_upd_t data_i,
  input  logic     pop_i,
  input  logic     flush_i,
  output btb_upd_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  btb_upd_t      mem_q [FIFO_DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Flush wins over any push/pop offered in the same cycle.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB RAM write-port controller: zero sweep after reset/flush, then drains queued updates.
//   state    | meaning
//   BTB_INIT | sweeping every entry to zero, one index per cycle; queue held
//   BTB_RUN  | one queued update written per cycle while the queue is non-empty
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 upd_valid_i,
  input  logic [BTB_INDEX-1:0] upd_index_i,
  input  logic [BTB_WIDTH-1:0] upd_data_i,
  output logic                 upd_ready_o,
  input  logic                 flush_i,
  output logic                 init_done_o,
  output logic [BTB_INDEX-1:0] wr_addr_o,
  output logic [BTB_WIDTH-1:0] wr_data_o,
  output logic                 wr_en_o
);

  // Extra bit keeps the last sweep index distinct from a wrapped counter.
  localparam logic [BTB_INDEX:0] SWEEP_LAST = (BTB_INDEX+1)'(BTB_DEPTH - 1);

  btb_state_e           state_q, state_d;
  logic [BTB_INDEX:0]   cnt_q, cnt_d;
  logic                 wr_en_q, wr_en_d;
  logic [BTB_INDEX-1:0] wr_addr_q, wr_addr_d;
  logic [BTB_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                 done_q, done_d;

  btb_upd_t fifo_in, fifo_head;
  logic     fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign upd_ready_o = !fifo_full && !flush_i;
  assign fifo_push   = upd_valid_i && upd_ready_o;
  assign fifo_pop    = (state_q == BTB_RUN) && !fifo_empty && !flush_i;
  assign fifo_in     = '{index: upd_index_i, data: upd_data_i};

  btb_upd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .flush_i (flush_i),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next state, sweep counter and next write-port values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    if (flush_i) begin
      state_d = BTB_INIT;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        BTB_INIT: begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[BTB_INDEX-1:0];
          wr_data_d = '0;
          cnt_d     = cnt_q + (BTB_INDEX+1)'(1);
          if (cnt_q == SWEEP_LAST) begin
            state_d = BTB_RUN;
            done_d  = 1'b1;
          end
        end
        BTB_RUN: begin
          if (!fifo_empty) begin
            wr_en_d   = 1'b1;
            wr_addr_d = fifo_head.index;
            wr_data_d = fifo_head.data;
          end
        end
        default: state_d = BTB_INIT;
      endcase
    end
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BTB_INIT;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign init_done_o = done_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: every expected RAM write is queued when
// stimulus is driven and checked in order when the DUT presents it.
module tb_btb_update_ctrl;

  logic        clk;
  logic        reset;
  logic        upd_valid_i;
  logic [5:0]  upd_index_i;
  logic [31:0] upd_data_i;
  logic        upd_ready_o;
  logic        flush_i;
  logic        init_done_o;
  logic [5:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic        wr_en_o;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ram [64];
  int          n_tests = 0;
  int          n_fail  = 0;

  btb_update_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .upd_valid_i (upd_valid_i),
    .upd_index_i (upd_index_i),
    .upd_data_i  (upd_data_i),
    .upd_ready_o (upd_ready_o),
    .flush_i     (flush_i),
    .init_done_o (init_done_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .wr_en_o     (wr_en_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 64; i++) sb.push_back('{addr: 6'(i), data: 32'h0});
  endtask

  task automatic drive_upd(input logic [5:0] idx, input logic [31:0] dat);
    upd_valid_i = 1'b1;
    upd_index_i = idx;
    upd_data_i  = dat;
  endtask

  // Returns at #1 after the edge where init_done_o rises.
  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (init_done_o) seen = 1;
    end
    if (!seen) chk(tag, 0, 1);
  endtask

  // Behavioural BTB RAM.
  always @(posedge clk) begin
    if (wr_en_o) ram[wr_addr_o] <= wr_data_o;
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!reset && wr_en_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_wr", {wr_addr_o, wr_data_o}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", wr_addr_o, e.addr);
        chk("wr_data", wr_data_o, e.data);
      end
    end
  end

  initial begin
    reset       = 1'b0;
    flush_i     = 1'b0;
    upd_valid_i = 1'b0;
    upd_index_i = '0;
    upd_data_i  = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_wr_addr", wr_addr_o, 0);
    chk("rst_wr_data", wr_data_o, 0);
    chk("rst_done", init_done_o, 0);
    chk("rst_ready", upd_ready_o, 1);
    push_sweep();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Initial sweep.
    @(posedge clk); #1;
    chk("sweep0_en", wr_en_o, 1);
    chk("sweep0_addr", wr_addr_o, 0);
    wait_done("sweep1_timeout");
    chk("done_with_addr63", wr_addr_o, 63);
    chk("done_with_en", wr_en_o, 1);
    @(posedge clk); #1;
    chk("idle_after_sweep", wr_en_o, 0);
    chk("sweep1_drained", sb.size(), 0);

    // Single update latency.
    drive_upd(6'd5, 32'hDEADBEEF);
    chk("ready_idle", upd_ready_o, 1);
    sb.push_back('{addr: 6'd5, data: 32'hDEADBEEF});
    @(posedge clk); #1;
    upd_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("lat_en", wr_en_o, 1);
    chk("lat_addr", wr_addr_o, 5);
    chk("lat_data", wr_data_o, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("ram5", ram[5], 32'hDEADBEEF);

    // Same index twice; later wins.
    drive_upd(6'd7, 32'h1);
    sb.push_back('{addr: 6'd7, data: 32'h1});
    @(posedge clk); #1;
    drive_upd(6'd7, 32'h2);
    sb.push_back('{addr: 6'd7, data: 32'h2});
    @(posedge clk); #1;
    upd_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ram7_last", ram[7], 32'h2);
    chk("q_drained_run", sb.size(), 0);

    // Flush from idle RUN; offered update must be refused.
    flush_i = 1'b1;
    drive_upd(6'd9, 32'h99);
    #1;
    chk("ready_in_flush", upd_ready_o, 0);
    push_sweep();
    @(posedge clk); #1;
    flush_i     = 1'b0;
    upd_valid_i = 1'b0;
    chk("flush_gap_en", wr_en_o, 0);
    chk("flush_done_low", init_done_o, 0);

    // Updates during INIT: 4 accepted, then back-pressure.
    for (int k = 0; k < 6; k++) begin
      drive_upd(6'(10 + k), 32'h100 + k);
      #1;
      chk("init_ready", upd_ready_o, (k < 4) ? 1 : 0);
      if (k < 4) sb.push_back('{addr: 6'(10 + k), data: 32'h100 + k});
      @(posedge clk); #1;
    end
    upd_valid_i = 1'b0;
    wait_done("sweep2_timeout");
    chk("full_at_run", upd_ready_o, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("drain_en", wr_en_o, 1);
      chk("drain_ready", upd_ready_o, 1);
    end
    @(posedge clk); #1;
    chk("drain_idle", wr_en_o, 0);
    chk("q_drained_init", sb.size(), 0);

    // Flush with 3 queued entries at the first RUN cycle.
    flush_i = 1'b1;
    push_sweep();
    @(posedge clk); #1;
    flush_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_upd(6'(20 + k), 32'hA0 + k);
      sb.push_back('{addr: 6'(20 + k), data: 32'hA0 + k});
      @(posedge clk); #1;
    end
    upd_valid_i = 1'b0;
    wait_done("sweep3_timeout");
    flush_i = 1'b1;
    repeat (3) void'(sb.pop_back());
    push_sweep();
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush3_gap_en", wr_en_o, 0);
    chk("flush3_done_low", init_done_o, 0);
    @(posedge clk); #1;
    chk("flush3_first_addr", wr_addr_o, 0);
    chk("flush3_first_en", wr_en_o, 1);

    // Async reset mid-sweep (counter = 30).
    begin
      bit hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
        if (wr_en_o && wr_addr_o == 6'd29) hit = 1;
        else begin
          @(posedge clk); #1;
        end
      end
      if (!hit) chk("addr29_timeout", 0, 1);
    end
    #1 reset = 1'b1;
    sb.delete();
    #1;
    chk("arst_wr_en", wr_en_o, 0);
    chk("arst_wr_addr", wr_addr_o, 0);
    chk("arst_wr_data", wr_data_o, 0);
    chk("arst_done", init_done_o, 0);
    push_sweep();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("restart_addr", wr_addr_o, 0);
    chk("restart_en", wr_en_o, 1);
    wait_done("sweep4_timeout");
    @(posedge clk); #1;
    chk("final_idle", wr_en_o, 0);
    chk("ram5_cleared", ram[5], 0);
    chk("ram7_cleared", ram[7], 0);
    @(negedge clk); #1;
    chk("final_q_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
